// File: rtl/playback_sequencer.sv
// playback_sequencer: fetches one 32-bit word per sample pair from flash and emits
// its two 16-bit halves paced by sample_tick. It also drives the address_controller
// with step, direction and reset controls.
// Optional build macro: PB_MUTE_ON_PAUSE_EN forces sample_out to 0 while paused.
module playback_sequencer #(
  parameter int ADDR_WIDTH = 23,
  parameter int SAMPLE_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_play,
  input  logic                  cmd_pause,
  input  logic                  cmd_forward,
  input  logic                  cmd_backward,
  input  logic                  cmd_restart,
  input  logic                  sample_tick,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic                  addr_change,
  output logic                  addr_forward,
  output logic                  addr_rst,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic                  mem_waitrequest,
  input  logic                  mem_readdatavalid,
  input  logic [2*SAMPLE_W-1:0] mem_readdata,
  output logic [SAMPLE_W-1:0]   sample_out,
  output logic                  sample_valid,
  output logic                  playing,
  output logic                  overrun
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    WAIT_DATA = 3'd2,
    HOLD      = 3'd3,
    STEP      = 3'd4
  } state_t;

  state_t              state;
  logic                restart_pending;
  logic                addr_rst_pulse;
  logic [SAMPLE_W-1:0] sample_reg;
  logic [SAMPLE_W-1:0] second_half;
  logic                restart_apply;
  logic                tick_busy;

  // A restart only takes effect where no flash transaction is in flight.
  assign restart_apply = restart_pending && ((state == IDLE) || (state == HOLD));
  // States in which an incoming tick cannot be served and is therefore lost.
  assign tick_busy     = (state == REQ) || (state == WAIT_DATA) || (state == STEP);

  // The address controller is held in reset for as long as we are.
  assign addr_rst = !rst || addr_rst_pulse;

`ifdef PB_MUTE_ON_PAUSE_EN
  assign sample_out = playing ? sample_reg : '0;
`else
  assign sample_out = sample_reg;
`endif

  // Playback FSM together with the command, direction, restart and overrun registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      restart_pending <= 1'b0;
      addr_rst_pulse  <= 1'b0;
      addr_change     <= 1'b0;
      addr_forward    <= 1'b1;
      mem_read        <= 1'b0;
      mem_address     <= '0;
      sample_reg      <= '0;
      second_half     <= '0;
      sample_valid    <= 1'b0;
      playing         <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      sample_valid   <= 1'b0;
      addr_change    <= 1'b0;
      addr_rst_pulse <= 1'b0;

      // Pause takes priority over play.
      if (cmd_pause)
        playing <= 1'b0;
      else if (cmd_play)
        playing <= 1'b1;

      // Opposing direction commands in the same cycle cancel each other.
      if (cmd_forward && !cmd_backward)
        addr_forward <= 1'b1;
      else if (cmd_backward && !cmd_forward)
        addr_forward <= 1'b0;

      restart_pending <= cmd_restart || (restart_pending && !restart_apply);

      if (sample_tick && tick_busy)
        overrun <= 1'b1;

      if (restart_apply) begin
        addr_rst_pulse <= 1'b1;
        overrun        <= 1'b0;
        second_half    <= '0;
        state          <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (sample_tick && playing) begin
              mem_read    <= 1'b1;
              mem_address <= address;
              state       <= REQ;
            end
          end
          REQ: begin
            if (!mem_waitrequest) begin
              mem_read <= 1'b0;
              state    <= WAIT_DATA;
            end
          end
          WAIT_DATA: begin
            // Half order is frozen here; a later direction change affects the next word.
            if (mem_readdatavalid) begin
              if (addr_forward) begin
                sample_reg  <= mem_readdata[SAMPLE_W-1:0];
                second_half <= mem_readdata[2*SAMPLE_W-1:SAMPLE_W];
              end else begin
                sample_reg  <= mem_readdata[2*SAMPLE_W-1:SAMPLE_W];
                second_half <= mem_readdata[SAMPLE_W-1:0];
              end
              sample_valid <= 1'b1;
              state        <= HOLD;
            end
          end
          HOLD: begin
            if (sample_tick && playing) begin
              sample_reg   <= second_half;
              sample_valid <= 1'b1;
              state        <= STEP;
            end
          end
          STEP: begin
            addr_change <= 1'b1;
            state       <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_playback_sequencer.sv
// Testbench for playback_sequencer: directed scenarios followed by randomized words,
// checked against a word-level model of expected addresses, sample order and timing.
module tb_playback_sequencer;

  localparam int AW = 23;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_play, cmd_pause, cmd_forward, cmd_backward, cmd_restart;
  logic          sample_tick;
  logic [AW-1:0] address;
  logic          addr_change, addr_forward, addr_rst;
  logic          mem_read;
  logic [AW-1:0] mem_address;
  logic          mem_waitrequest, mem_readdatavalid;
  logic [31:0]   mem_readdata;
  logic [SW-1:0] sample_out;
  logic          sample_valid, playing, overrun;

  int checks = 0;
  int errors = 0;
  int accepts = 0;

  // Behavioural stand-in for the address_controller plus a preload hook.
  logic          ld;
  logic [AW-1:0] ld_val;
  logic [AW-1:0] ac;
  assign address = ac;

  // Model state at word granularity.
  logic [AW-1:0] exp_addr;
  logic          exp_fwd;

  playback_sequencer #(.ADDR_WIDTH(AW), .SAMPLE_W(SW)) dut (
    .clk(clk), .rst(rst),
    .cmd_play(cmd_play), .cmd_pause(cmd_pause), .cmd_forward(cmd_forward),
    .cmd_backward(cmd_backward), .cmd_restart(cmd_restart), .sample_tick(sample_tick),
    .address(address), .addr_change(addr_change), .addr_forward(addr_forward),
    .addr_rst(addr_rst), .mem_read(mem_read), .mem_address(mem_address),
    .mem_waitrequest(mem_waitrequest), .mem_readdatavalid(mem_readdatavalid),
    .mem_readdata(mem_readdata), .sample_out(sample_out), .sample_valid(sample_valid),
    .playing(playing), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (addr_rst)         ac <= '0;
    else if (ld)          ac <= ld_val;
    else if (addr_change) ac <= addr_forward ? ac + 1'b1 : ac - 1'b1;
  end

  always @(posedge clk) begin
    if (rst && mem_read && !mem_waitrequest) accepts++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SW-1:0] first_half(input logic [31:0] w, input logic fwd);
    return fwd ? w[15:0] : w[31:16];
  endfunction

  function automatic logic [SW-1:0] second_half(input logic [31:0] w, input logic fwd);
    return fwd ? w[31:16] : w[15:0];
  endfunction

  // One full word: tick, read (with stalls), data, first sample, tick, second sample, step.
  task automatic do_word(input int nwait, input int rd_lat, input logic [31:0] data, input int gap);
    int a0;
    a0 = accepts;
    sample_tick = 1'b1; step(); sample_tick = 1'b0;
    chk("rd_start", mem_read, 1'b1);
    chk("rd_addr", mem_address, exp_addr);
    mem_waitrequest = (nwait > 0);
    for (int i = 0; i < nwait; i++) begin
      step();
      chk("rd_stall", mem_read, 1'b1);
      chk("rd_stall_addr", mem_address, exp_addr);
    end
    mem_waitrequest = 1'b0;
    step();
    chk("rd_drop", mem_read, 1'b0);
    for (int i = 0; i < rd_lat; i++) step();
    mem_readdatavalid = 1'b1; mem_readdata = data;
    step();
    mem_readdatavalid = 1'b0;
    chk("s1_valid", sample_valid, 1'b1);
    chk("s1_data", sample_out, first_half(data, exp_fwd));
    for (int i = 0; i < gap; i++) begin
      step();
      chk("hold_quiet", sample_valid, 1'b0);
    end
    sample_tick = 1'b1; step(); sample_tick = 1'b0;
    chk("s2_valid", sample_valid, 1'b1);
    chk("s2_data", sample_out, second_half(data, exp_fwd));
    step();
    chk("step_pulse", addr_change, 1'b1);
    chk("step_dir", addr_forward, exp_fwd);
    chk("one_accept", accepts - a0, 1);
    exp_addr = exp_fwd ? exp_addr + 1'b1 : exp_addr - 1'b1;
    step();
    chk("step_end", addr_change, 1'b0);
  endtask

  initial begin
    logic [31:0] w;
    int r;
    rst = 1'b0;
    cmd_play = 0; cmd_pause = 0; cmd_forward = 0; cmd_backward = 0; cmd_restart = 0;
    sample_tick = 0; mem_waitrequest = 0; mem_readdatavalid = 0; mem_readdata = '0;
    ld = 0; ld_val = '0;
    exp_fwd = 1'b1;
    step(); step();
    chk("rst_playing", playing, 1'b0);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_addr_fwd", addr_forward, 1'b1);
    chk("rst_addr_rst", addr_rst, 1'b1);
    chk("rst_valid", sample_valid, 1'b0);
    chk("rst_sample", sample_out, 16'h0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_change", addr_change, 1'b0);
    rst = 1'b1;
    step();
    chk("rst_release", addr_rst, 1'b0);

    // 1: forward word at address 5
    ld = 1; ld_val = 23'd5; step(); ld = 0;
    exp_addr = 23'd5;
    cmd_play = 1; step(); cmd_play = 0;
    chk("play", playing, 1'b1);
    do_word(0, 0, 32'hBBBB_AAAA, 1);

    // 2: backward order
    cmd_backward = 1; step(); cmd_backward = 0;
    exp_fwd = 1'b0;
    chk("dir_back", addr_forward, 1'b0);
    do_word(0, 1, 32'hBBBB_AAAA, 1);

    // 3: stalled request
    cmd_forward = 1; step(); cmd_forward = 0;
    exp_fwd = 1'b1;
    chk("dir_fwd", addr_forward, 1'b1);
    do_word(4, 2, 32'h1234_5678, 0);

    // 4: overrun then restart while holding
    w = 32'hCAFE_F00D;
    sample_tick = 1; step(); sample_tick = 0;
    chk("t4_read", mem_read, 1'b1);
    step();
    sample_tick = 1; step(); sample_tick = 0;
    chk("t4_overrun", overrun, 1'b1);
    mem_readdatavalid = 1; mem_readdata = w; step(); mem_readdatavalid = 0;
    chk("t4_s1", sample_out, first_half(w, 1'b1));
    step();
    chk("t4_single", sample_valid, 1'b0);
    cmd_restart = 1; step(); cmd_restart = 0;
    step();
    chk("t4_addr_rst", addr_rst, 1'b1);
    chk("t4_ovr_clr", overrun, 1'b0);
    chk("t4_playing", playing, 1'b1);
    step();
    chk("t4_rst_pulse", addr_rst, 1'b0);
    exp_addr = '0;
    do_word(0, 0, 32'h0F0F_A5A5, 0);

    // 5: pause during WAIT_DATA
    w = 32'h5555_3333;
    sample_tick = 1; step(); sample_tick = 0;
    step();
    cmd_pause = 1; step(); cmd_pause = 0;
    chk("t5_paused", playing, 1'b0);
    mem_readdatavalid = 1; mem_readdata = w; step(); mem_readdatavalid = 0;
    chk("t5_s1_valid", sample_valid, 1'b1);
`ifdef PB_MUTE_ON_PAUSE_EN
    chk("t5_s1", sample_out, 16'h0);
`else
    chk("t5_s1", sample_out, first_half(w, 1'b1));
`endif
    for (int i = 0; i < 3; i++) begin
      sample_tick = 1; step(); sample_tick = 0;
      chk("t5_hold_ignore", sample_valid, 1'b0);
    end
    chk("t5_no_ovr", overrun, 1'b0);
    cmd_play = 1; step(); cmd_play = 0;
    chk("t5_resume", playing, 1'b1);
    chk("t5_held", sample_out, first_half(w, 1'b1));
    sample_tick = 1; step(); sample_tick = 0;
    chk("t5_s2_valid", sample_valid, 1'b1);
    chk("t5_s2", sample_out, second_half(w, 1'b1));
    step();
    chk("t5_step", addr_change, 1'b1);
    exp_addr = exp_addr + 1'b1;
    step();

    // 6: async reset during REQ
    sample_tick = 1; step(); sample_tick = 0;
    mem_waitrequest = 1;
    chk("t6_req", mem_read, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("t6_read_drop", mem_read, 1'b0);
    chk("t6_addr_rst", addr_rst, 1'b1);
    step();
    chk("t6_addr_rst_hold", addr_rst, 1'b1);
    rst = 1'b1; mem_waitrequest = 0;
    mem_readdatavalid = 1; mem_readdata = 32'hDEAD_BEEF; step(); mem_readdatavalid = 0;
    chk("t6_late_data", sample_valid, 1'b0);
    chk("t6_idle", mem_read, 1'b0);
    exp_addr = '0; exp_fwd = 1'b1;

    // Randomized words with random direction commands, stalls and latencies
    cmd_play = 1; step(); cmd_play = 0;
    for (int k = 0; k < 20; k++) begin
      r = $urandom_range(0, 3);
      cmd_forward  = (r == 0) || (r == 2);
      cmd_backward = (r == 1) || (r == 2);
      step();
      cmd_forward = 0; cmd_backward = 0;
      if (r == 0) exp_fwd = 1'b1;
      if (r == 1) exp_fwd = 1'b0;
      chk("rnd_dir", addr_forward, exp_fwd);
      do_word($urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom_range(0, 3));
      r = $urandom_range(0, 2);
      for (int i = 0; i < r; i++) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
